// File: rtl/dm_pkg.sv
// Shared constants for the data-memory arbiter.
//   DM_BIT_WIDTH / DM_ADDR_WIDTH : memory word and address widths
//   DM_STARVE_LIMIT              : cycles B may lose to A before it wins
//   TAG_A / TAG_B                : owner tag carried with an outstanding read
package dm_pkg;

    localparam int unsigned DM_BIT_WIDTH    = 32;
    localparam int unsigned DM_ADDR_WIDTH   = 10;
    localparam int unsigned DM_STARVE_LIMIT = 4;

    localparam logic TAG_A = 1'b0;
    localparam logic TAG_B = 1'b1;

endpackage : dm_pkg

// File: rtl/dm_starve_ctr.sv
// Saturating count of consecutive cycles in which B requested but was not granted.
//   clk, rst  : clock, synchronous active-low reset
//   b_req     : B requests this cycle
//   b_gnt     : B granted this cycle
//   at_limit  : counter has reached STARVE_LIMIT (B must win the next conflict)
module dm_starve_ctr
    import dm_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DM_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic b_req,
    input  logic b_gnt,
    output logic at_limit
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] cnt;

    // Count a lost cycle, hold at the limit, clear on grant or when B drops its request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (b_req && !b_gnt) begin
            if (cnt != CNT_W'(STARVE_LIMIT)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

    assign at_limit = (cnt == CNT_W'(STARVE_LIMIT));

endmodule : dm_starve_ctr

// File: rtl/dm_arbiter.sv
// Shares a single-port, 1-cycle registered-read data memory between the pipeline
// MEM stage (port A, favoured) and the loader/debug reader (port B).
//   clk, rst                                  : clock, synchronous active-low reset
//   a_req/a_we/a_addr/a_wdata                 : A request (hold until a_gnt)
//   a_gnt                                     : A access issued this cycle (combinational)
//   a_rvalid/a_rdata                          : A read data, one cycle after grant
//   b_*                                       : same set for B
//   mem_addr/mem_wdata/mem_wr                 : memory drive from the granted port
//   mem_rdata                                 : registered memory read data
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int unsigned bit_width    = DM_BIT_WIDTH,
    parameter int unsigned addr_width   = DM_ADDR_WIDTH,
    parameter int unsigned STARVE_LIMIT = DM_STARVE_LIMIT
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [addr_width-1:0] a_addr,
    input  logic [bit_width-1:0]  a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [bit_width-1:0]  a_rdata,

    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [addr_width-1:0] b_addr,
    input  logic [bit_width-1:0]  b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [bit_width-1:0]  b_rdata,

    output logic [addr_width-1:0] mem_addr,
    output logic [bit_width-1:0]  mem_wdata,
    output logic                  mem_wr,
    input  logic [bit_width-1:0]  mem_rdata
);

    logic at_limit;
    logic rd_pend;
    logic rd_tag;

    dm_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .b_req    (b_req),
        .b_gnt    (b_gnt),
        .at_limit (at_limit)
    );

    // Grant: A wins conflicts unless B has waited STARVE_LIMIT cycles; nothing while in reset.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (rst) begin
            if (a_req && b_req) begin
                if (at_limit) begin
                    b_gnt = 1'b1;
                end else begin
                    a_gnt = 1'b1;
                end
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end
    end

    // Memory drive: B only when granted, otherwise A's lines (harmless with mem_wr low).
    always_comb begin
        mem_addr  = a_addr;
        mem_wdata = a_wdata;
        if (b_gnt) begin
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
        end
        mem_wr = (a_gnt && a_we) || (b_gnt && b_we);
    end

    // Read-tag pipeline: remembers who owns the data the memory returns next cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_pend <= 1'b0;
            rd_tag  <= TAG_A;
        end else begin
            rd_pend <= (a_gnt && !a_we) || (b_gnt && !b_we);
            rd_tag  <= b_gnt ? TAG_B : TAG_A;
        end
    end

    // Response demux. Gating with rst drops a read whose return cycle coincides with reset.
    assign a_rvalid = rd_pend && (rd_tag == TAG_A) && rst;
    assign b_rvalid = rd_pend && (rd_tag == TAG_B) && rst;
    assign a_rdata  = a_rvalid ? mem_rdata : '0;
    assign b_rdata  = b_rvalid ? mem_rdata : '0;

endmodule : dm_arbiter

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter paired with a 1024x32 registered-read memory model.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [9:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_wr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_gnt     (a_gnt),
        .a_rvalid  (a_rvalid),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_gnt     (b_gnt),
        .b_rvalid  (b_rvalid),
        .b_rdata   (b_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata)
    );

    // Memory model: write on posedge, registered read (read-before-write of the same edge).
    logic [31:0] mem [1024];
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic        ar, aw;
        logic [9:0]  aa;
        logic [31:0] ad;
        logic        br, bw;
        logic [9:0]  ba;
        logic [31:0] bd;
        logic        e_ag, e_bg, e_wr, e_arv;
        logic [31:0] e_ard;
        logic        e_brv;
        logic [31:0] e_brd;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic ar, aw, input logic [9:0] aa, input logic [31:0] ad,
                                input logic br, bw, input logic [9:0] ba, input logic [31:0] bd,
                                input logic e_ag, e_bg, e_wr, e_arv, input logic [31:0] e_ard,
                                input logic e_brv, input logic [31:0] e_brd);
        vec_t v;
        v.ar = ar; v.aw = aw; v.aa = aa; v.ad = ad;
        v.br = br; v.bw = bw; v.ba = ba; v.bd = bd;
        v.e_ag = e_ag; v.e_bg = e_bg; v.e_wr = e_wr;
        v.e_arv = e_arv; v.e_ard = e_ard; v.e_brv = e_brv; v.e_brd = e_brd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ar, aw, input logic [9:0] aa, input logic [31:0] ad,
                         input logic br, bw, input logic [9:0] ba, input logic [31:0] bd);
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    endtask

    task automatic idle();
        drive(0, 0, 10'd0, 32'd0, 0, 0, 10'd0, 32'd0);
    endtask

    initial begin
        // T1: A write 5 -> 3, A read 3, return
        vecs[0]  = mk(1,1,10'd3,32'd5,        0,0,10'd0,32'd0,          1,0,1, 0,32'd0, 0,32'd0);
        vecs[1]  = mk(1,0,10'd3,32'd0,        0,0,10'd0,32'd0,          1,0,0, 0,32'd0, 0,32'd0);
        vecs[2]  = mk(0,0,10'd0,32'd0,        0,0,10'd0,32'd0,          0,0,0, 1,32'd5, 0,32'd0);
        // T3: B alone write/read top address
        vecs[3]  = mk(0,0,10'd0,32'd0,        1,1,10'd1023,32'hDEADBEEF, 0,1,1, 0,32'd0, 0,32'd0);
        vecs[4]  = mk(0,0,10'd0,32'd0,        1,0,10'd1023,32'd0,       0,1,0, 0,32'd0, 0,32'd0);
        vecs[5]  = mk(0,0,10'd0,32'd0,        0,0,10'd0,32'd0,          0,0,0, 0,32'd0, 1,32'hDEADBEEF);
        // T2: both read every cycle -> A,A,A,A,B repeating
        vecs[6]  = mk(1,0,10'd3,32'd0,        1,0,10'd1023,32'd0,       1,0,0, 0,32'd0, 0,32'd0);
        vecs[7]  = mk(1,0,10'd3,32'd0,        1,0,10'd1023,32'd0,       1,0,0, 1,32'd5, 0,32'd0);
        vecs[8]  = mk(1,0,10'd3,32'd0,        1,0,10'd1023,32'd0,       1,0,0, 1,32'd5, 0,32'd0);
        vecs[9]  = mk(1,0,10'd3,32'd0,        1,0,10'd1023,32'd0,       1,0,0, 1,32'd5, 0,32'd0);
        vecs[10] = mk(1,0,10'd3,32'd0,        1,0,10'd1023,32'd0,       0,1,0, 1,32'd5, 0,32'd0);
        vecs[11] = mk(1,0,10'd3,32'd0,        1,0,10'd1023,32'd0,       1,0,0, 0,32'd0, 1,32'hDEADBEEF);
        vecs[12] = mk(1,0,10'd3,32'd0,        1,0,10'd1023,32'd0,       1,0,0, 1,32'd5, 0,32'd0);
        vecs[13] = mk(1,0,10'd3,32'd0,        1,0,10'd1023,32'd0,       1,0,0, 1,32'd5, 0,32'd0);
        vecs[14] = mk(1,0,10'd3,32'd0,        1,0,10'd1023,32'd0,       1,0,0, 1,32'd5, 0,32'd0);
        vecs[15] = mk(1,0,10'd3,32'd0,        1,0,10'd1023,32'd0,       0,1,0, 1,32'd5, 0,32'd0);
        vecs[16] = mk(0,0,10'd0,32'd0,        0,0,10'd0,32'd0,          0,0,0, 0,32'd0, 1,32'hDEADBEEF);
        // T5: counter to 3, B alone clears it, A wins next conflict
        vecs[17] = mk(1,0,10'd3,32'd0,        1,0,10'd1023,32'd0,       1,0,0, 0,32'd0, 0,32'd0);
        vecs[18] = mk(1,0,10'd3,32'd0,        1,0,10'd1023,32'd0,       1,0,0, 1,32'd5, 0,32'd0);
        vecs[19] = mk(1,0,10'd3,32'd0,        1,0,10'd1023,32'd0,       1,0,0, 1,32'd5, 0,32'd0);
        vecs[20] = mk(0,0,10'd0,32'd0,        1,0,10'd1023,32'd0,       0,1,0, 1,32'd5, 0,32'd0);
        vecs[21] = mk(1,0,10'd3,32'd0,        1,0,10'd1023,32'd0,       1,0,0, 0,32'd0, 1,32'hDEADBEEF);
        vecs[22] = mk(0,0,10'd0,32'd0,        0,0,10'd0,32'd0,          0,0,0, 1,32'd5, 0,32'd0);

        // Reset with both ports asking to write: no grant, no write.
        rst = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        drive(1, 1, 10'd5, 32'd1, 1, 1, 10'd6, 32'd2);
        #1;
        chk("reset a_gnt", 32'(a_gnt), 32'd0);
        chk("reset b_gnt", 32'(b_gnt), 32'd0);
        chk("reset mem_wr", 32'(mem_wr), 32'd0);

        // First cycle after release: responses quiet.
        @(negedge clk);
        rst = 1'b1;
        idle();
        #1;
        chk("release a_rvalid", 32'(a_rvalid), 32'd0);
        chk("release b_rvalid", 32'(b_rvalid), 32'd0);
        chk("release a_rdata", a_rdata, 32'd0);
        chk("release b_rdata", b_rdata, 32'd0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].ar, vecs[i].aw, vecs[i].aa, vecs[i].ad,
                  vecs[i].br, vecs[i].bw, vecs[i].ba, vecs[i].bd);
            #1;
            chk($sformatf("v%0d a_gnt", i),    32'(a_gnt),    32'(vecs[i].e_ag));
            chk($sformatf("v%0d b_gnt", i),    32'(b_gnt),    32'(vecs[i].e_bg));
            chk($sformatf("v%0d mem_wr", i),   32'(mem_wr),   32'(vecs[i].e_wr));
            chk($sformatf("v%0d a_rvalid", i), 32'(a_rvalid), 32'(vecs[i].e_arv));
            chk($sformatf("v%0d a_rdata", i),  a_rdata,       vecs[i].e_ard);
            chk($sformatf("v%0d b_rvalid", i), 32'(b_rvalid), 32'(vecs[i].e_brv));
            chk($sformatf("v%0d b_rdata", i),  b_rdata,       vecs[i].e_brd);
        end

        // T4: mem[7] = 9, build counter to 3, then reset right after an A read grant.
        @(negedge clk);
        drive(0, 0, 10'd0, 32'd0, 1, 1, 10'd7, 32'd9);
        #1;
        chk("t4 preload b_gnt", 32'(b_gnt), 32'd1);
        for (int q = 0; q < 3; q++) begin
            @(negedge clk);
            drive(1, 0, 10'd7, 32'd0, 1, 0, 10'd0, 32'd0);
            #1;
            chk($sformatf("t4 pre%0d a_gnt", q), 32'(a_gnt), 32'd1);
            if (q > 0) chk($sformatf("t4 pre%0d a_rdata", q), a_rdata, 32'd9);
        end
        for (int q = 0; q < 2; q++) begin
            @(negedge clk);
            rst = 1'b0;
            drive(1, 1, 10'd7, 32'd0, 1, 1, 10'd0, 32'd0);
            #1;
            chk($sformatf("t4 rst%0d a_rvalid", q), 32'(a_rvalid), 32'd0);
            chk($sformatf("t4 rst%0d a_rdata", q), a_rdata, 32'd0);
            chk($sformatf("t4 rst%0d a_gnt", q), 32'(a_gnt), 32'd0);
            chk($sformatf("t4 rst%0d b_gnt", q), 32'(b_gnt), 32'd0);
            chk($sformatf("t4 rst%0d mem_wr", q), 32'(mem_wr), 32'd0);
        end
        // After release a cleared counter gives A four wins before B.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rst = 1'b1;
            drive(1, 0, 10'd7, 32'd0, 1, 0, 10'd0, 32'd0);
            #1;
            if (k == 0) chk("t4 release a_rvalid", 32'(a_rvalid), 32'd0);
            chk($sformatf("t4 post%0d a_gnt", k), 32'(a_gnt), (k == 4) ? 32'd0 : 32'd1);
            chk($sformatf("t4 post%0d b_gnt", k), 32'(b_gnt), (k == 4) ? 32'd1 : 32'd0);
        end

        // T6: preload 0..15 with 2*i through B, then 16 back-to-back A reads.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(0, 0, 10'd0, 32'd0, 1, 1, 10'(i), 32'(2 * i));
            #1;
            chk($sformatf("t6 load%0d b_gnt", i), 32'(b_gnt), 32'd1);
        end
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            if (k < 16) drive(1, 0, 10'(k), 32'd0, 0, 0, 10'd0, 32'd0);
            else        idle();
            #1;
            chk($sformatf("t6 c%0d a_gnt", k), 32'(a_gnt), (k < 16) ? 32'd1 : 32'd0);
            chk($sformatf("t6 c%0d a_rvalid", k), 32'(a_rvalid), (k > 0) ? 32'd1 : 32'd0);
            chk($sformatf("t6 c%0d a_rdata", k), a_rdata, (k > 0) ? 32'(2 * (k - 1)) : 32'd0);
            chk($sformatf("t6 c%0d b_rvalid", k), 32'(b_rvalid), 32'd0);
        end
        @(negedge clk);
        idle();
        #1;
        chk("t6 tail a_rvalid", 32'(a_rvalid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_dm_arbiter
